// File: rtl/loadreg_multi.sv
// loadreg_multi: multi-mode WIDTH-bit register with serial out, change history and saturating update counter
module loadreg_multi #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  input  logic [SW-1:0]    hist_sel,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic [WIDTH-1:0] hist_q,
  output logic [CNT_W-1:0] upd_cnt,
  output logic             zero
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [WIDTH-1:0] hist_mem_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg;
  always_comb begin
    q_d = mode == 3'd1 ? D :
          mode == 3'd2 ? {q_q[WIDTH-2:0], sin} :
          mode == 3'd3 ? {sin, q_q[WIDTH-1:1]} :
          mode == 3'd4 ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
          mode == 3'd5 ? {q_q[0], q_q[WIDTH-1:1]} :
          mode == 3'd6 ? '0 :
          mode == 3'd7 ? q_q + 1'b1 : q_q;
    sout_d = (mode == 3'd2 || mode == 3'd4) ? q_q[WIDTH-1] :
             (mode == 3'd3 || mode == 3'd5) ? q_q[0] : sout_q;
    chg = q_d != q_q;
    hist_d = hist_mem_q;
    if (chg) begin
      hist_d[0] = q_q;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_mem_q[i-1];
    end
    cnt_d = (chg && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
      sout_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      q_q <= q_d;
      sout_q <= sout_d;
      hist_mem_q <= hist_d;
      cnt_q <= cnt_d;
    end
  end
  assign Q = q_q;
  assign sout = sout_q;
  assign hist_q = (32'(hist_sel) < DEPTH) ? hist_mem_q[hist_sel] : '0;
  assign upd_cnt = cnt_q;
  assign zero = q_q == '0;
endmodule
